hazard_sequencer: RTL and testbench

- Central hazard and sequencing controller for the RV32IM 5-stage pipeline.
- Drives stall and flush controls for the F/D, D/E and E/M pipeline registers. The flush outputs wire directly to each register's sclr input.
- Generates E-stage operand forwarding selects.
- Sequences the iterative divider: holds the pipeline for DIV_LAT cycles while a DIV/DIVU/REM/REMU sits in E.

---
 rtl/hazard_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_hazard_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// ---------------------------------------------------------------------------
// hazard_sequencer
//
// Central hazard and sequencing controller for the RV32IM 5-stage pipeline.
// Produces stall and flush controls for the F/D, D/E and E/M pipeline
// registers, the E-stage operand forwarding selects, and sequences the
// iterative divider while a DIV/DIVU/REM/REMU instruction sits in E.
//
// The flush outputs drive the sclr input of each pipeline register.
// All stall, flush and forward outputs are combinational from the current
// divider state and the current inputs.
//
// Optional build macro:
//   HAZARD_PERF_EN  adds the stall_cnt / flush_cnt performance counters.
//                   When undefined the ports and counters are absent.
//
// Parameters:
//   DIV_LAT   divider cycles before the result is valid (1..63)
//   WB_LOAD   wb_sel encoding that marks a load
//
// Ports:
//   clk         pipeline clock
//   sclr        synchronous active-high reset
//   rs1_addrD   D-stage source 1          rs2_addrD   D-stage source 2
//   rs1_addrE   E-stage source 1          rs2_addrE   E-stage source 2
//   rd_addrE    E-stage destination       rd_wrenE    E-stage writes rd
//   wb_selE     E-stage writeback select
//   rd_addrM    M-stage destination       rd_wrenM    M-stage writes rd
//   rd_addrW    W-stage destination       rd_wrenW    W-stage writes rd
//   br_takenE   branch/jump redirect resolved in E
//   div_reqE    divide/remainder instruction in E
//   stallF      hold PC
//   stallD      hold F/D register
//   stallE      hold D/E register
//   flushD      clear F/D register
//   flushE      clear D/E register
//   flushM      clear E/M register
//   fwd_a_selE  operand A source: 00 regfile, 01 W result, 10 M result
//   fwd_b_selE  operand B source, same encoding
//   div_busy    divider running
//   div_done    divider result valid this cycle
//   stall_cnt   (HAZARD_PERF_EN) cycles with stallF set, wraps at 2^32
//   flush_cnt   (HAZARD_PERF_EN) cycles with flushD or flushE set
// ---------------------------------------------------------------------------
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no divide in flight; a div_reqE seen here starts the divider
// DIV_RUN  | divider iterating; pipeline held, bubble fed into M
// DIV_DONE | result valid for one cycle; the divide advances to M
//
module hazard_sequencer #(
  parameter int         DIV_LAT = 32,
  parameter logic [1:0] WB_LOAD = 2'b01
) (
  input  logic       clk,
  input  logic       sclr,
  input  logic [4:0] rs1_addrD,
  input  logic [4:0] rs2_addrD,
  input  logic [4:0] rs1_addrE,
  input  logic [4:0] rs2_addrE,
  input  logic [4:0] rd_addrE,
  input  logic       rd_wrenE,
  input  logic [1:0] wb_selE,
  input  logic [4:0] rd_addrM,
  input  logic       rd_wrenM,
  input  logic [4:0] rd_addrW,
  input  logic       rd_wrenW,
  input  logic       br_takenE,
  input  logic       div_reqE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic [1:0] fwd_a_selE,
  output logic [1:0] fwd_b_selE,
  output logic       div_busy,
  output logic       div_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

  // Counter is loaded with DIV_LAT-1 so that the terminal count of zero
  // marks the last of exactly DIV_LAT run cycles.
  localparam logic [5:0] CNT_LOAD = 6'(DIV_LAT - 1);

  divState_t  state;
  divState_t  stateNext;
  logic [5:0] cnt;
  logic [5:0] cntNext;

  logic       loadUse;
  logic       divRun;

  // ------------------------------------------------------------------------
  // Forwarding
  // ------------------------------------------------------------------------
  function automatic logic [1:0] fwdSel(
    input logic [4:0] srcAddr,
    input logic       wrenM,
    input logic [4:0] addrM,
    input logic       wrenW,
    input logic [4:0] addrW
  );
    logic [1:0] sel;
    sel = 2'b00;
    // M is the younger producer, so it wins over W; x0 is never forwarded.
    if (wrenM && (addrM != 5'd0) && (addrM == srcAddr)) begin
      sel = 2'b10;
    end else if (wrenW && (addrW != 5'd0) && (addrW == srcAddr)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign fwd_a_selE = fwdSel(rs1_addrE, rd_wrenM, rd_addrM, rd_wrenW, rd_addrW);
  assign fwd_b_selE = fwdSel(rs2_addrE, rd_wrenM, rd_addrM, rd_wrenW, rd_addrW);

  // ------------------------------------------------------------------------
  // Load-use detection
  // ------------------------------------------------------------------------
  assign loadUse = (wb_selE == WB_LOAD) && rd_wrenE && (rd_addrE != 5'd0) &&
                   ((rd_addrE == rs1_addrD) || (rd_addrE == rs2_addrD));

  // ------------------------------------------------------------------------
  // Divider FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sclr) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (div_reqE) begin
          stateNext = DIV_RUN;
          cntNext   = CNT_LOAD;
        end
      end
      DIV_RUN: begin
        if (cnt == 6'd0) begin
          stateNext = DIV_DONE;
        end else begin
          cntNext = cnt - 6'd1;
        end
      end
      DIV_DONE: begin
        // The divide still presents div_reqE this cycle; returning to IDLE
        // unconditionally keeps it from restarting the divider.
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 6'd0;
      end
    endcase
  end

  assign divRun   = (state == DIV_RUN);
  assign div_busy = divRun;
  assign div_done = (state == DIV_DONE);

  // ------------------------------------------------------------------------
  // Stall / flush resolution
  // ------------------------------------------------------------------------
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (divRun) begin
      // E holds the divide, so hazards seen in E cannot clear anything;
      // the whole front end freezes and M receives a bubble.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else begin
      flushD = br_takenE;
      flushE = br_takenE | loadUse;
      stallF = loadUse;
      // A flush of F/D overrides the load-use hold of that register.
      stallD = loadUse & ~br_takenE;
      stallE = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  // ------------------------------------------------------------------------
  // Performance counters
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sclr) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stallF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flushD | flushE) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  typedef struct packed {
    logic [4:0] rs1D;
    logic [4:0] rs2D;
    logic [4:0] rs1E;
    logic [4:0] rs2E;
    logic [4:0] rdE;
    logic       wrenE;
    logic [1:0] wbE;
    logic [4:0] rdM;
    logic       wrenM;
    logic [4:0] rdW;
    logic       wrenW;
    logic       br;
    logic       div;
    logic       sclr;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [11:0] exp;
  } vec_t;

  // Output vector layout:
  // {stallF, stallD, stallE, flushD, flushE, flushM, fwdA[1:0], fwdB[1:0], busy, done}
  localparam logic [11:0] O_RUN  = 12'b111_001_00_00_1_0;
  localparam logic [11:0] O_DONE = 12'b000_000_00_00_0_1;
  localparam logic [11:0] O_LU   = 12'b110_010_00_00_0_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t cur;
  int  checks   = 0;
  int  failures = 0;

  logic sF4, sD4, sE4, fD4, fE4, fM4, bz4, dn4;
  logic [1:0] fa4, fb4;
  logic sF1, sD1, sE1, fD1, fE1, fM1, bz1, dn1;
  logic [1:0] fa1, fb1;
`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt4, flushCnt4, stallCnt1, flushCnt1;
`endif

  hazard_sequencer #(.DIV_LAT(4), .WB_LOAD(2'b01)) u_dut (
    .clk(clk), .sclr(cur.sclr),
    .rs1_addrD(cur.rs1D), .rs2_addrD(cur.rs2D),
    .rs1_addrE(cur.rs1E), .rs2_addrE(cur.rs2E),
    .rd_addrE(cur.rdE), .rd_wrenE(cur.wrenE), .wb_selE(cur.wbE),
    .rd_addrM(cur.rdM), .rd_wrenM(cur.wrenM),
    .rd_addrW(cur.rdW), .rd_wrenW(cur.wrenW),
    .br_takenE(cur.br), .div_reqE(cur.div),
    .stallF(sF4), .stallD(sD4), .stallE(sE4),
    .flushD(fD4), .flushE(fE4), .flushM(fM4),
    .fwd_a_selE(fa4), .fwd_b_selE(fb4),
    .div_busy(bz4), .div_done(dn4)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stallCnt4), .flush_cnt(flushCnt4)
`endif
  );

  hazard_sequencer #(.DIV_LAT(1), .WB_LOAD(2'b01)) u_dut1 (
    .clk(clk), .sclr(cur.sclr),
    .rs1_addrD(cur.rs1D), .rs2_addrD(cur.rs2D),
    .rs1_addrE(cur.rs1E), .rs2_addrE(cur.rs2E),
    .rd_addrE(cur.rdE), .rd_wrenE(cur.wrenE), .wb_selE(cur.wbE),
    .rd_addrM(cur.rdM), .rd_wrenM(cur.wrenM),
    .rd_addrW(cur.rdW), .rd_wrenW(cur.wrenW),
    .br_takenE(cur.br), .div_reqE(cur.div),
    .stallF(sF1), .stallD(sD1), .stallE(sE1),
    .flushD(fD1), .flushE(fE1), .flushM(fM1),
    .fwd_a_selE(fa1), .fwd_b_selE(fb1),
    .div_busy(bz1), .div_done(dn1)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stallCnt1), .flush_cnt(flushCnt1)
`endif
  );

  wire [11:0] out4 = {sF4, sD4, sE4, fD4, fE4, fM4, fa4, fb4, bz4, dn4};
  wire [11:0] out1 = {sF1, sD1, sE1, fD1, fE1, fM1, fa1, fb1, bz1, dn1};

  // Reference model state: remaining stall cycles and a one-shot done flag.
  int          rem4, rem1;
  bit          done4, done1;
  logic [31:0] perfStall, perfFlush;

  function automatic logic [1:0] fwdRule(input logic [4:0] src, input in_t i);
    if (i.wrenM && i.rdM != 0 && i.rdM == src) return 2'b10;
    if (i.wrenW && i.rdW != 0 && i.rdW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] modelOut(input in_t i, input int rem, input bit dn);
    logic lu, sF, sD, sE, fD, fE, fM;
    lu = (i.wbE == 2'b01) && i.wrenE && (i.rdE != 0) &&
         ((i.rdE == i.rs1D) || (i.rdE == i.rs2D));
    if (rem > 0) begin
      {sF, sD, sE, fD, fE, fM} = 6'b111_001;
    end else begin
      fD = i.br;
      fE = i.br | lu;
      sF = lu;
      sD = lu & ~fD;
      sE = 1'b0;
      fM = 1'b0;
    end
    return {sF, sD, sE, fD, fE, fM, fwdRule(i.rs1E, i), fwdRule(i.rs2E, i),
            1'(rem > 0), 1'(dn)};
  endfunction

  task automatic advance(input int lat, input in_t i, inout int rem, inout bit dn);
    if (i.sclr) begin
      rem = 0;
      dn  = 0;
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) dn = 1;
    end else if (dn) begin
      dn = 0;
    end else if (i.div) begin
      rem = lat;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One cycle: compare at negedge, then let the edge happen and step the model.
  task automatic tick(input string name, input bit useExp, input logic [11:0] exp4);
    logic [11:0] m4, m1;
    @(negedge clk);
    m4 = modelOut(cur, rem4, done4);
    m1 = modelOut(cur, rem1, done1);
    check(name, 32'(out4), useExp ? 32'(exp4) : 32'(m4));
    check({name, "_lat1"}, 32'(out1), 32'(m1));
`ifdef HAZARD_PERF_EN
    check({name, "_stall_cnt"}, stallCnt4, perfStall);
    check({name, "_flush_cnt"}, flushCnt4, perfFlush);
`endif
    @(posedge clk);
    if (cur.sclr) begin
      perfStall = 0;
      perfFlush = 0;
    end else begin
      perfStall = perfStall + 32'(m4[11]);
      perfFlush = perfFlush + 32'(m4[8] | m4[7]);
    end
    advance(4, cur, rem4, done4);
    advance(1, cur, rem1, done1);
    #1;
  endtask

  vec_t tbl[12];

  initial begin
    in_t v;
    // ---------------- combinational vectors ----------------
    v = '0; tbl[0] = '{"reset_zero", v, 12'b0};
    v = '0; v.wrenM = 1; v.rdM = 5; v.wrenW = 1; v.rdW = 5; v.rs1E = 5;
    tbl[1] = '{"fwd_a_m_prio", v, 12'b000_000_10_00_0_0};
    v.rdM = 0;
    tbl[2] = '{"fwd_a_w", v, 12'b000_000_01_00_0_0};
    v.rs1E = 0; v.rdW = 0;
    tbl[3] = '{"fwd_x0", v, 12'b0};
    v = '0; v.wrenM = 1; v.rdM = 9; v.rs2E = 9; v.wrenW = 1; v.rdW = 3; v.rs1E = 3;
    tbl[4] = '{"fwd_b_m_a_w", v, 12'b000_000_01_10_0_0};
    v = '0; v.rdM = 5; v.rdW = 5; v.rs1E = 5; v.rs2E = 5;
    tbl[5] = '{"fwd_no_wren", v, 12'b0};
    v = '0; v.wbE = 2'b01; v.wrenE = 1; v.rdE = 7; v.rs2D = 7;
    tbl[6] = '{"loaduse_rs2", v, O_LU};
    v.rdE = 0; v.rs2D = 0;
    tbl[7] = '{"loaduse_x0", v, 12'b0};
    v = '0; v.wbE = 2'b01; v.wrenE = 1; v.rdE = 12; v.rs1D = 12;
    tbl[8] = '{"loaduse_rs1", v, O_LU};
    v.wbE = 2'b00;
    tbl[9] = '{"not_load", v, 12'b0};
    v = '0; v.br = 1;
    tbl[10] = '{"redirect", v, 12'b000_110_00_00_0_0};
    v = '0; v.br = 1; v.wbE = 2'b01; v.wrenE = 1; v.rdE = 4; v.rs1D = 4;
    tbl[11] = '{"redirect_and_lu", v, 12'b100_110_00_00_0_0};

    // ---------------- reset ----------------
    cur = '0;
    cur.sclr = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rem4 = 0; rem1 = 0; done4 = 0; done1 = 0; perfStall = 0; perfFlush = 0;
    cur.sclr = 0;

    for (int k = 0; k < 12; k++) begin
      cur = tbl[k].in;
      tick(tbl[k].name, 1'b1, tbl[k].exp);
    end

    // ---------------- back-to-back divides, DIV_LAT=4 ----------------
    cur = '0;
    for (int k = 0; k < 12; k++) begin
      logic [11:0] e;
      cur.div = 1;
      if (k == 0 || k == 6)      e = 12'b0;
      else if (k == 5 || k == 11) e = O_DONE;
      else                        e = O_RUN;
      tick($sformatf("div_b2b_c%0d", k), 1'b1, e);
    end
    cur = '0;
    tick("div_after_idle", 1'b1, 12'b0);

    // ---------------- reset mid-divide ----------------
    cur = '0; cur.div = 1;
    tick("rst_mid_idle", 1'b1, 12'b0);
    tick("rst_mid_run1", 1'b1, O_RUN);
    cur.sclr = 1;
    tick("rst_mid_run2", 1'b1, O_RUN);
    cur = '0;
    tick("rst_mid_after", 1'b1, 12'b0);

    // ---------------- perf sequence: one load-use + one divide ----------------
    cur = '0; cur.sclr = 1;
    tick("perf_clr", 1'b1, 12'b0);
    cur = '0; cur.wbE = 2'b01; cur.wrenE = 1; cur.rdE = 7; cur.rs2D = 7;
    tick("perf_lu", 1'b1, O_LU);
    cur = '0; cur.div = 1;
    for (int k = 0; k < 6; k++)
      tick($sformatf("perf_div_c%0d", k), 1'b1,
           (k == 0) ? 12'b0 : (k == 5) ? O_DONE : O_RUN);
    cur = '0;
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    check("perf_stall_total", stallCnt4, 32'd5);
    check("perf_flush_total", flushCnt4, 32'd1);
`endif
    check("perf_end_idle", 32'(out4), 32'd0);
    @(posedge clk);
    #1;

    // ---------------- randomized against the model ----------------
    for (int n = 0; n < 500; n++) begin
      cur.rs1D  = 5'($urandom_range(0, 3));
      cur.rs2D  = 5'($urandom_range(0, 3));
      cur.rs1E  = 5'($urandom_range(0, 3));
      cur.rs2E  = 5'($urandom_range(0, 3));
      cur.rdE   = 5'($urandom_range(0, 3));
      cur.rdM   = 5'($urandom_range(0, 3));
      cur.rdW   = 5'($urandom_range(0, 3));
      cur.wrenE = 1'($urandom_range(0, 1));
      cur.wrenM = 1'($urandom_range(0, 1));
      cur.wrenW = 1'($urandom_range(0, 1));
      cur.wbE   = 2'($urandom_range(0, 3));
      cur.br    = ($urandom_range(0, 5) == 0);
      cur.div   = ($urandom_range(0, 3) == 0);
      cur.sclr  = ($urandom_range(0, 59) == 0);
      tick("rand", 1'b0, 12'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
